icache_ctrl: RTL and testbench
==============================

Name: icache_ctrl

Overview:
- Instruction-cache controller between the CPU fetch stage and the instruction-cache SRAM array (tag/data/valid/PLRU storage with async hit/read and sync write).
- Looks up each fetch PC in the array and returns the selected 32-bit instruction on a hit.
- On a miss, stalls fetch, fetches the block from main memory as BLOCK_WORDS word beats, writes it into the array, then replays the lookup.

Parameters:
- ADDR_W, 32, byte address width of the fetch PC.
- WORD_W, 32, instruction and memory beat width.
- BLOCK_WORDS, 4, words per cache block; power of two; block bits = BLOCK_WORDS*WORD_W (equals IBLOCK_SIZE_BITS).
- INDEX_W, ISET_INDEX_SIZE, set index width.
- TAG_W, ITAG_SIZE, tag width; TAG_W+INDEX_W+log2(BLOCK_WORDS)+2 = ADDR_W.

Ports:
- clk  in  1  clock; one clock domain, all state updates on its rising edge.
- rst  in  1  reset; synchronous and active-high.
- cpu_req_valid  in  1  fetch request valid.
- cpu_pc  in  ADDR_W  fetch byte address, word aligned.
- cpu_flush  in  1  discard any outstanding fetch (branch redirect).
- cpu_instr  out  WORD_W  instruction returned.
- cpu_instr_valid  out  1  cpu_instr valid this cycle.
- cpu_stall  out  1  fetch must hold; high while a miss is in progress.
- sram_en  out  1  array enable.
- sram_memWen  out  1  array fill write.
- sram_blockAddr  out  TAG_W+INDEX_W  {tag,index} presented to the array.
- sram_dataIn  out  BLOCK_WORDS*WORD_W  write data to the array.
- sram_hit  in  1  async hit from the array.
- sram_dataOut  in  BLOCK_WORDS*WORD_W  async block from the array.
- mem_req_valid  out  1  block read request.
- mem_req_ready  in  1  memory accepts request.
- mem_req_addr  out  ADDR_W  block-aligned byte address.
- mem_resp_valid  in  1  one response beat valid.
- mem_resp_data  in  WORD_W  beat data, word 0 first.

Behaviour:
- Address split: cpu_pc = {tag, index, word_off[log2 BLOCK_WORDS], 2'b00}. Word i of a block occupies bits [WORD_W*i +: WORD_W].
- Reset (rst=1 at a clock edge):
  - FSM returns to IDLE; beat counter, line buffer, latched address and flush_pending are cleared.
  - All outputs are 0 in the following cycle.
- FSM states: IDLE, MISS_REQ, MISS_FILL, WRITE, REPLAY.
- IDLE:
  - sram_en = cpu_req_valid; sram_blockAddr = cpu_pc tag/index.
  - sram_dataIn = sram_dataOut. The array rewrites the hit line on every enabled hit to update PLRU, so the controller feeds the read data back unchanged.
  - Hit: cpu_instr_valid = 1 and cpu_instr = selected word, in the same cycle (zero-cycle hit).
  - Miss with cpu_flush = 0: latch cpu_pc, assert cpu_stall combinationally, next state MISS_REQ.
  - cpu_flush = 1 in IDLE: no lookup is started.
- MISS_REQ:
  - mem_req_valid = 1; mem_req_addr = latched PC with offset bits zeroed.
  - Request is held stable until mem_req_ready = 1, then next state MISS_FILL.
- MISS_FILL:
  - Each mem_resp_valid stores mem_resp_data at line_buf[beat] and increments beat.
  - On beat BLOCK_WORDS-1: beat wraps to 0, next state WRITE.
  - Beats arriving in any other state are ignored.
- WRITE: one cycle with sram_en = 1, sram_memWen = 1, sram_blockAddr = latched, sram_dataIn = line_buf; next state REPLAY.
- REPLAY:
  - sram_en = 1 at the latched address; the array now hits.
  - cpu_instr_valid = 1 unless flush_pending; cpu_stall = 0; next state IDLE.
- cpu_stall: high in MISS_REQ, MISS_FILL and WRITE, and combinationally in the IDLE miss cycle.
- cpu_flush during MISS_REQ/MISS_FILL/WRITE:
  - Sets flush_pending. The fill always completes; memory requests are never cancelled.
  - REPLAY then suppresses cpu_instr_valid, and flush_pending clears.
- cpu_pc and cpu_req_valid are ignored outside IDLE.
- Only one miss is outstanding at a time.

Optional Feature:
- ICACHE_PERF_CNT_EN defined:
  - Adds outputs perf_hits and perf_misses, 32 bits each, cleared by rst.
  - perf_hits increments on each IDLE hit delivered; perf_misses on each IDLE-to-MISS_REQ transition.
  - Both counters saturate at 0xFFFFFFFF.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared constants header (existing constants.vh): ITAG_SIZE, ISET_INDEX_SIZE, IBLOCK_SIZE_BITS, IBLOCK_WORDS, and the FSM state encodings ICTRL_IDLE..ICTRL_REPLAY.
- One natural sub-module: icache_line_fill, containing the beat counter and line buffer with load/clear/done signals.

Test Plan:
- Reset, then request PC 0x100 on an empty array -> cpu_stall=1, mem_req_addr=0x100; beats 0xA0,0xA1,0xA2,0xA3 -> one WRITE cycle with data {A3,A2,A1,A0}; REPLAY returns cpu_instr=0xA0 with valid=1.
- Request PC 0x108 next -> same-cycle hit, cpu_instr=0xA2, no memory request.
- Miss with mem_req_ready held low for 5 cycles -> mem_req_valid and mem_req_addr stable all 5 cycles; exactly one request accepted.
- cpu_flush pulsed during beat 2 -> fill completes, array written, no cpu_instr_valid in REPLAY; re-request hits.
- rst asserted after beat 1 -> next cycle IDLE, all outputs 0; remaining beats ignored; re-request misses and refills cleanly.
- Two tags mapping to the same index, alternating -> both stay resident (2-way), hits after the initial fills; with ICACHE_PERF_CNT_EN, perf_misses=2.

Source files
------------

// File: rtl/icache_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : icache_ctrl_pkg
//  Description : Shared instruction-cache geometry and controller state codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package icache_ctrl_pkg;

    localparam int ITAG_SIZE        = 22;
    localparam int ISET_INDEX_SIZE  = 6;
    localparam int IBLOCK_WORDS     = 4;
    localparam int IWORD_SIZE       = 32;
    localparam int IBLOCK_SIZE_BITS = IBLOCK_WORDS * IWORD_SIZE;

    localparam logic [2:0] ICTRL_IDLE      = 3'd0;
    localparam logic [2:0] ICTRL_MISS_REQ  = 3'd1;
    localparam logic [2:0] ICTRL_MISS_FILL = 3'd2;
    localparam logic [2:0] ICTRL_WRITE     = 3'd3;
    localparam logic [2:0] ICTRL_REPLAY    = 3'd4;

endpackage
`default_nettype wire

// File: rtl/icache_ctrl_line_fill.sv
`default_nettype none
// ============================================================================
//  Module      : icache_line_fill
//  Description : Beat counter and line buffer assembling a refill block.
//  Revision    : 1.0 - initial release
// ============================================================================
module icache_line_fill #(
    parameter int WORD_W      = 32,
    parameter int BLOCK_WORDS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic                          load,
    input  logic [WORD_W-1:0]             load_data,
    output logic                          done,
    output logic [BLOCK_WORDS*WORD_W-1:0] line
);

    localparam int                 c_CNT_W = $clog2(BLOCK_WORDS);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(BLOCK_WORDS - 1);

    logic [c_CNT_W-1:0] r_beat;

    assign done = load && (r_beat == c_LAST);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_beat <= '0;
        end else if (load) begin
            r_beat <= done ? '0 : r_beat + 1'b1;
        end
    end

    generate
        for (genvar g = 0; g < BLOCK_WORDS; g++) begin : g_word
            logic [WORD_W-1:0] r_word;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_word <= '0;
                end else if (load && (r_beat == c_CNT_W'(g))) begin
                    r_word <= load_data;
                end
            end

            assign line[g*WORD_W +: WORD_W] = r_word;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/icache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : icache_ctrl
//  Description : Instruction-cache controller: zero-cycle hits, blocking
//                single-miss refill with replay. Optional performance
//                counters when ICACHE_PERF_CNT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module icache_ctrl
    import icache_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int WORD_W      = 32,
    parameter int BLOCK_WORDS = IBLOCK_WORDS,
    parameter int INDEX_W     = ISET_INDEX_SIZE,
    parameter int TAG_W       = ITAG_SIZE
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cpu_req_valid,
    input  logic [ADDR_W-1:0]             cpu_pc,
    input  logic                          cpu_flush,
    output logic [WORD_W-1:0]             cpu_instr,
    output logic                          cpu_instr_valid,
    output logic                          cpu_stall,
    output logic                          sram_en,
    output logic                          sram_memWen,
    output logic [TAG_W+INDEX_W-1:0]      sram_blockAddr,
    output logic [BLOCK_WORDS*WORD_W-1:0] sram_dataIn,
    input  logic                          sram_hit,
    input  logic [BLOCK_WORDS*WORD_W-1:0] sram_dataOut,
    output logic                          mem_req_valid,
    input  logic                          mem_req_ready,
    output logic [ADDR_W-1:0]             mem_req_addr,
    input  logic                          mem_resp_valid,
    input  logic [WORD_W-1:0]             mem_resp_data
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]                   perf_hits,
    output logic [31:0]                   perf_misses
`endif
);

    localparam int c_OFF_W = $clog2(BLOCK_WORDS);
    localparam int c_LOW_W = c_OFF_W + 2;
    localparam int c_BLK_W = BLOCK_WORDS * WORD_W;

    logic [2:0]         r_state;
    logic [2:0]         w_next_state;
    logic [ADDR_W-1:0]  r_pc;
    logic               r_flush_pending;
    logic               w_lookup;
    logic               w_miss;
    logic               w_fill_load;
    logic               w_fill_done;
    logic [c_BLK_W-1:0] w_line;
    logic [c_OFF_W-1:0] w_pc_off;
    logic [c_OFF_W-1:0] w_latched_off;
    logic               w_filling;

    assign w_lookup      = (r_state == ICTRL_IDLE) && cpu_req_valid && !cpu_flush;
    assign w_miss        = w_lookup && !sram_hit;
    assign w_fill_load   = (r_state == ICTRL_MISS_FILL) && mem_resp_valid;
    assign w_pc_off      = cpu_pc[c_LOW_W-1:2];
    assign w_latched_off = r_pc[c_LOW_W-1:2];
    assign w_filling     = (r_state == ICTRL_MISS_REQ) || (r_state == ICTRL_MISS_FILL) ||
                           (r_state == ICTRL_WRITE);

    icache_line_fill #(
        .WORD_W      (WORD_W),
        .BLOCK_WORDS (BLOCK_WORDS)
    ) u_line_fill (
        .clk       (clk),
        .rst       (rst),
        .clear     (w_miss),
        .load      (w_fill_load),
        .load_data (mem_resp_data),
        .done      (w_fill_done),
        .line      (w_line)
    );

    always_comb begin
        w_next_state    = r_state;
        cpu_instr       = '0;
        cpu_instr_valid = 1'b0;
        cpu_stall       = 1'b0;
        sram_en         = 1'b0;
        sram_memWen     = 1'b0;
        sram_blockAddr  = '0;
        sram_dataIn     = '0;
        mem_req_valid   = 1'b0;
        mem_req_addr    = '0;
        case (r_state)
            ICTRL_IDLE: begin
                if (w_lookup) begin
                    // Hit lines are written back unchanged so the array can refresh PLRU.
                    sram_en        = 1'b1;
                    sram_blockAddr = cpu_pc[ADDR_W-1:c_LOW_W];
                    sram_dataIn    = sram_dataOut;
                    if (sram_hit) begin
                        cpu_instr_valid = 1'b1;
                        cpu_instr       = sram_dataOut[WORD_W*w_pc_off +: WORD_W];
                    end else begin
                        cpu_stall    = 1'b1;
                        w_next_state = ICTRL_MISS_REQ;
                    end
                end
            end
            ICTRL_MISS_REQ: begin
                cpu_stall     = 1'b1;
                mem_req_valid = 1'b1;
                mem_req_addr  = {r_pc[ADDR_W-1:c_LOW_W], {c_LOW_W{1'b0}}};
                if (mem_req_ready) begin
                    w_next_state = ICTRL_MISS_FILL;
                end
            end
            ICTRL_MISS_FILL: begin
                cpu_stall = 1'b1;
                if (w_fill_done) begin
                    w_next_state = ICTRL_WRITE;
                end
            end
            ICTRL_WRITE: begin
                cpu_stall      = 1'b1;
                sram_en        = 1'b1;
                sram_memWen    = 1'b1;
                sram_blockAddr = r_pc[ADDR_W-1:c_LOW_W];
                sram_dataIn    = w_line;
                w_next_state   = ICTRL_REPLAY;
            end
            ICTRL_REPLAY: begin
                sram_en         = 1'b1;
                sram_blockAddr  = r_pc[ADDR_W-1:c_LOW_W];
                sram_dataIn     = sram_dataOut;
                cpu_instr_valid = !r_flush_pending;
                if (!r_flush_pending) begin
                    cpu_instr = sram_dataOut[WORD_W*w_latched_off +: WORD_W];
                end
                w_next_state = ICTRL_IDLE;
            end
            default: begin
                w_next_state = ICTRL_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ICTRL_IDLE;
            r_pc            <= '0;
            r_flush_pending <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_miss) begin
                r_pc <= cpu_pc;
            end
            // A redirect mid-refill lets the fill finish but drops the replayed word.
            if (r_state == ICTRL_REPLAY) begin
                r_flush_pending <= 1'b0;
            end else if (cpu_flush && w_filling) begin
                r_flush_pending <= 1'b1;
            end
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_hits   <= '0;
            perf_misses <= '0;
        end else begin
            if (w_lookup && sram_hit && (perf_hits != 32'hFFFF_FFFF)) begin
                perf_hits <= perf_hits + 32'd1;
            end
            if (w_miss && (perf_misses != 32'hFFFF_FFFF)) begin
                perf_misses <= perf_misses + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_icache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_icache_ctrl
//  Description : Self-checking bench for icache_ctrl with a 2-way LRU array
//                and a block-residency reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_ctrl;
    import icache_ctrl_pkg::*;

    localparam int c_TAG_W = ITAG_SIZE;
    localparam int c_IDX_W = ISET_INDEX_SIZE;
    localparam int c_SETS  = 1 << c_IDX_W;
    localparam int c_BLK_W = IBLOCK_SIZE_BITS;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      cpu_req_valid;
    logic [31:0]               cpu_pc;
    logic                      cpu_flush;
    logic [31:0]               cpu_instr;
    logic                      cpu_instr_valid;
    logic                      cpu_stall;
    logic                      sram_en;
    logic                      sram_memWen;
    logic [c_TAG_W+c_IDX_W-1:0] sram_blockAddr;
    logic [c_BLK_W-1:0]        sram_dataIn;
    logic                      sram_hit;
    logic [c_BLK_W-1:0]        sram_dataOut;
    logic                      mem_req_valid;
    logic                      mem_req_ready;
    logic [31:0]               mem_req_addr;
    logic                      mem_resp_valid;
    logic [31:0]               mem_resp_data;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0]               perf_hits;
    logic [31:0]               perf_misses;
`endif

    int checks = 0;
    int errors = 0;
    int exp_hits = 0;
    int exp_misses = 0;

    always #5 clk = ~clk;

    icache_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .cpu_req_valid   (cpu_req_valid),
        .cpu_pc          (cpu_pc),
        .cpu_flush       (cpu_flush),
        .cpu_instr       (cpu_instr),
        .cpu_instr_valid (cpu_instr_valid),
        .cpu_stall       (cpu_stall),
        .sram_en         (sram_en),
        .sram_memWen     (sram_memWen),
        .sram_blockAddr  (sram_blockAddr),
        .sram_dataIn     (sram_dataIn),
        .sram_hit        (sram_hit),
        .sram_dataOut    (sram_dataOut),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_req_addr    (mem_req_addr),
        .mem_resp_valid  (mem_resp_valid),
        .mem_resp_data   (mem_resp_data)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .perf_hits       (perf_hits),
        .perf_misses     (perf_misses)
`endif
    );

    // Environment: 2-way set-associative array, async read, sync write, LRU replacement.
    logic [c_TAG_W-1:0] arr_tag  [c_SETS][2];
    logic               arr_val  [c_SETS][2];
    logic [c_BLK_W-1:0] arr_data [c_SETS][2];
    logic               arr_lru  [c_SETS];
    logic               arr_clr;
    logic [c_IDX_W-1:0] a_idx;
    logic [c_TAG_W-1:0] a_tag;
    logic               a_hit;
    logic               a_way;
    logic               a_fill_way;

    always_comb begin
        a_idx = sram_blockAddr[c_IDX_W-1:0];
        a_tag = sram_blockAddr[c_TAG_W+c_IDX_W-1:c_IDX_W];
        a_hit = 1'b0;
        a_way = 1'b0;
        for (int w = 0; w < 2; w++) begin
            if (arr_val[a_idx][w] && (arr_tag[a_idx][w] == a_tag)) begin
                a_hit = 1'b1;
                a_way = w[0];
            end
        end
        a_fill_way = a_hit ? a_way : (!arr_val[a_idx][0] ? 1'b0 :
                                      (!arr_val[a_idx][1] ? 1'b1 : arr_lru[a_idx]));
    end

    assign sram_hit     = sram_en && a_hit;
    assign sram_dataOut = a_hit ? arr_data[a_idx][a_way] : '0;

    always @(posedge clk) begin
        if (arr_clr) begin
            for (int s = 0; s < c_SETS; s++) begin
                arr_val[s][0] <= 1'b0;
                arr_val[s][1] <= 1'b0;
                arr_lru[s]    <= 1'b0;
            end
        end else if (sram_en) begin
            if (sram_memWen) begin
                arr_tag[a_idx][a_fill_way]  <= a_tag;
                arr_data[a_idx][a_fill_way] <= sram_dataIn;
                arr_val[a_idx][a_fill_way]  <= 1'b1;
                arr_lru[a_idx]              <= ~a_fill_way;
            end else if (a_hit) begin
                arr_data[a_idx][a_way] <= sram_dataIn;
                arr_lru[a_idx]         <= ~a_way;
            end
        end
    end

    // Reference: resident blocks in most-recent-first order, at most two per set.
    logic [27:0] ref_q[$];

    function automatic bit ref_has(input logic [27:0] blk);
        foreach (ref_q[i]) if (ref_q[i] == blk) return 1'b1;
        return 1'b0;
    endfunction

    task automatic ref_touch(input logic [27:0] blk);
        int n;
        int last;
        for (int i = 0; i < ref_q.size(); i++) begin
            if (ref_q[i] == blk) begin
                ref_q.delete(i);
                break;
            end
        end
        ref_q.push_front(blk);
        n = 0;
        last = -1;
        for (int i = 0; i < ref_q.size(); i++) begin
            if (ref_q[i][c_IDX_W-1:0] == blk[c_IDX_W-1:0]) begin
                n++;
                last = i;
            end
        end
        if (n > 2) ref_q.delete(last);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:4] == 28'h10) return 32'hA0 + {30'd0, a[3:2]};
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One fetch; rdy_dly = cycles before mem accepts, flush_beat/rst_beat = -1 for none.
    task automatic fetch(input logic [31:0] pc, input int rdy_dly, input int flush_beat,
                         input int rst_beat);
        logic [27:0]        blk;
        logic [c_BLK_W-1:0] exp_blk;
        logic [31:0]        wa;
        bit                 flushed;
        blk = pc[31:4];
        @(negedge clk);
        cpu_req_valid = 1'b1;
        cpu_pc = pc;
        #1;
        if (ref_has(blk)) begin
            check("hit_valid", cpu_instr_valid, 1);
            check("hit_instr", cpu_instr, mem_word(pc));
            check("hit_stall", cpu_stall, 0);
            check("hit_noreq", mem_req_valid, 0);
            ref_touch(blk);
            exp_hits++;
            return;
        end
        check("miss_valid", cpu_instr_valid, 0);
        check("miss_stall", cpu_stall, 1);
        exp_misses++;
        @(negedge clk);
        cpu_req_valid = 1'($urandom_range(0, 1));
        cpu_pc = $urandom & 32'hFFFF_FFFC;
        #1;
        for (int k = 0; k <= rdy_dly; k++) begin
            check("req_valid", mem_req_valid, 1);
            check("req_addr", mem_req_addr, {pc[31:4], 4'h0});
            check("req_stall", cpu_stall, 1);
            mem_req_ready  = (k == rdy_dly);
            mem_resp_valid = (k != rdy_dly);
            mem_resp_data  = $urandom;
            @(negedge clk);
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b0;
            #1;
        end
        check("req_once", mem_req_valid, 0);
        flushed = 1'b0;
        for (int b = 0; b < 4; b++) begin
            if ($urandom_range(0, 2) == 0) begin
                check("gap_stall", cpu_stall, 1);
                @(negedge clk);
                #1;
            end
            wa = {pc[31:4], 4'h0} + 32'(b * 4);
            mem_resp_valid = 1'b1;
            mem_resp_data  = mem_word(wa);
            if (b == flush_beat) begin
                cpu_flush = 1'b1;
                flushed = 1'b1;
            end
            if (rst_beat >= 0 && b == rst_beat + 1) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                cpu_req_valid = 1'b0;
                cpu_flush = 1'b0;
                mem_resp_data = $urandom;
                #1;
                check("rst_flags", {cpu_instr_valid, cpu_stall, sram_en, sram_memWen, mem_req_valid}, 0);
                check("rst_vectors", {cpu_instr, sram_blockAddr, mem_req_addr}, 0);
                check("rst_datain", sram_dataIn, 0);
                @(negedge clk);
                mem_resp_valid = 1'b0;
                #1;
                check("rst_idle", {cpu_stall, mem_req_valid, sram_memWen}, 0);
                exp_hits = 0;
                exp_misses = 0;
                return;
            end
            @(negedge clk);
            mem_resp_valid = 1'b0;
            cpu_flush = 1'b0;
            #1;
        end
        for (int b = 0; b < 4; b++) exp_blk[32*b +: 32] = mem_word({pc[31:4], 4'h0} + 32'(b * 4));
        check("wr_en", {sram_en, sram_memWen}, 2'b11);
        check("wr_addr", sram_blockAddr, pc[31:4]);
        check("wr_data", sram_dataIn, exp_blk);
        check("wr_stall", cpu_stall, 1);
        @(negedge clk);
        cpu_req_valid = 1'b0;
        #1;
        check("rp_stall", cpu_stall, 0);
        check("rp_valid", cpu_instr_valid, !flushed);
        if (!flushed) check("rp_instr", cpu_instr, mem_word(pc));
        ref_touch(blk);
    endtask

    initial begin
        logic [31:0] pc;
        int          fb;
`ifdef ICACHE_PERF_CNT_EN
        logic [31:0] m0;
`endif
        rst = 1'b1;
        arr_clr = 1'b1;
        cpu_req_valid = 1'b0;
        cpu_pc = '0;
        cpu_flush = 1'b0;
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        arr_clr = 1'b0;
        #1;
        check("reset_flags", {cpu_instr_valid, cpu_stall, sram_en, sram_memWen, mem_req_valid}, 0);
        check("reset_vectors", {cpu_instr, sram_blockAddr, mem_req_addr}, 0);

        fetch(32'h0000_0100, 0, -1, -1);
        fetch(32'h0000_0108, 0, -1, -1);
        fetch(32'h0000_2000, 5, -1, -1);

        @(negedge clk);
        cpu_req_valid = 1'b1;
        cpu_pc = 32'h0000_4000;
        cpu_flush = 1'b1;
        #1;
        check("flush_idle", {sram_en, cpu_stall, cpu_instr_valid}, 0);
        @(negedge clk);
        cpu_flush = 1'b0;
        cpu_req_valid = 1'b0;
        #1;
        check("flush_idle_next", {cpu_stall, mem_req_valid}, 0);

        fetch(32'h0000_3004, 0, 2, -1);
        fetch(32'h0000_3004, 0, -1, -1);
        fetch(32'h0000_500C, 1, -1, 1);
        fetch(32'h0000_5008, 0, -1, -1);
        fetch(32'h0000_5008, 0, -1, -1);

`ifdef ICACHE_PERF_CNT_EN
        m0 = perf_misses;
`endif
        fetch(32'h0000_1200, 0, -1, -1);
        fetch(32'h0001_1204, 2, -1, -1);
        fetch(32'h0000_1208, 0, -1, -1);
        fetch(32'h0001_120C, 0, -1, -1);
        fetch(32'h0000_1200, 0, -1, -1);
`ifdef ICACHE_PERF_CNT_EN
        check("perf_two_way", perf_misses - m0, 2);
`endif

        for (int n = 0; n < 150; n++) begin
            pc = (32'($urandom_range(0, 3)) << 14) | (32'($urandom_range(48, 51)) << 4) |
                 (32'($urandom_range(0, 3)) << 2);
            fb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
            fetch(pc, int'($urandom_range(0, 3)), fb, -1);
        end

`ifdef ICACHE_PERF_CNT_EN
        @(negedge clk);
        #1;
        check("perf_hits", perf_hits, 32'(exp_hits));
        check("perf_misses", perf_misses, 32'(exp_misses));
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
